retry_inorder_limited_end: RTL and testbench
============================================

# retry_inorder_limited_end

Parametrised successor to the in-order retry end stage. It sits at the output of a (pipelined) combinational operation whose inputs are issued by the matching retry start stage. It keeps results in order by replaying every element from a failure until a resume point. It bounds the number of consecutive replay windows and, once that bound is hit, forwards the failing element downstream with an error flag instead of retrying forever. It also exposes saturating event counters for monitoring.

## Interface
Parameters:
- `DataType`, default `logic`: payload type, passed through unmodified.
- `IDSize`, default 1: width of element IDs.
- `MaxRetries`, default 3: consecutive replay windows allowed before giving up; must be ≥ 1.
- `CntWidth`, default 16: width of the saturating status counters.

Ports:
- `clk_i` in, 1: clock; single clock domain.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `data_i` in, `DataType`: result payload.
- `id_i` in, `IDSize`: ID of the arriving element.
- `needs_retry_i` in, 1: arriving element is faulty.
- `valid_i` in, 1: upstream valid.
- `ready_o` out, 1: upstream ready.
- `data_o` out, `DataType`: equals `data_i`.
- `error_o` out, 1: qualifies `valid_o`; element forwarded after give-up.
- `valid_o` out, 1: downstream valid.
- `ready_i` in, 1: downstream ready.
- `retry_id_o` out, `IDSize`: equals `id_i`.
- `retry_id_i` in, `IDSize`: next ID the start stage will issue.
- `retry_valid_o` out, 1: element is sent back for replay.
- `retry_lock_o` out, 1: start stage must issue only from the replay path.
- `retry_ready_i` in, 1: start stage accepts a replay element.
- `retry_count_o` out, `CntWidth`: saturating count of replay windows opened.
- `giveup_count_o` out, `CntWidth`: saturating count of give-ups.

## Operation
- State register `state_q` has two values, `PASS` and `REPLAY`.
- Registers:
  - `resume_id_q` (`IDSize`)
  - `attempts_q`, width $clog2(MaxRetries+1)
  - two `CntWidth` counters
- Per-cycle routing decision `route_retry` (combinational):
  - In `PASS`: `route_retry = valid_i & needs_retry_i & (attempts_q < MaxRetries)`.
  - In `REPLAY` with `id_i != resume_id_q`: `route_retry = valid_i`.
  - In `REPLAY` with `id_i == resume_id_q`: the element is evaluated exactly as in `PASS`.
- Outputs when `route_retry` = 1:
  - `retry_valid_o = valid_i`, `ready_o = retry_ready_i`, `valid_o = 0`.
- Outputs when `route_retry` = 0:
  - `valid_o = valid_i`, `ready_o = ready_i`, `retry_valid_o = 0`.
- `error_o = valid_o & needs_retry_i`. It is only reachable when `attempts_q == MaxRetries`.
- `retry_lock_o = route_retry | (next state == REPLAY)`.
- State updates happen only on an accepted transfer (`valid_i & ready_o`):
  - Replay window opened (routed to retry, from `PASS` or from the resume element):
    - `state` → `REPLAY`
    - `resume_id` ← `retry_id_i`
    - `attempts` += 1
    - `retry_count` += 1, saturating
  - Routed to retry inside a window (ID ≠ resume): no register change.
  - Forwarded clean (`needs_retry_i` = 0): `state` → `PASS`, `attempts` ← 0.
  - Forwarded with error: `state` → `PASS`, `attempts` ← 0, `giveup_count` += 1, saturating.
- A resume element that itself fails reopens a window immediately (no drop, no stall).
- Counters saturate at 2^CntWidth−1 and never wrap.
- ID wrap-around is handled by the equality compare only; all in-flight IDs are unique.

## Timing
- Zero latency: every data, valid and ready path is combinational. No payload storage.
- State takes effect the cycle after the accepted transfer.
- `route_retry` depends on `state_q`, `resume_id_q`, `attempts_q`, `id_i` and `needs_retry_i`; it never depends on `ready_i` or `retry_ready_i`.
- `valid_i` held without a handshake leaves all registers unchanged, so routing stays stable while stalled.
- Reset values:
  - `state` = `PASS`; `resume_id`, `attempts` and both counters = 0.
  - With `valid_i` = 0, `valid_o`, `retry_valid_o`, `error_o` and `retry_lock_o` are all 0.
- Reset asserted mid-window returns to `PASS` asynchronously. Any in-flight replay context is lost; the start stage is reset together with this block.

## Structure
- Shared package `retry_pkg` holds the state enum `retry_state_e` {`PASS`, `REPLAY`}, reused by future retry variants.
- Sub-module `retry_sat_counter` (parameter `Width`; ports `clk_i`, `rst_ni`, `inc_i`, `count_o`) is instantiated twice for the status counters.
- Use the common-cells `FF` macros for all registers.

## Test plan
- Clean stream: IDs 0..7, `needs_retry_i` = 0, `ready_i` = 1.
  - Expect all 8 on `valid_o` in order, `retry_valid_o` never set, counters 0.
- Single failure: ID 2 fails with `retry_id_i` = 5, then IDs 3, 4 arrive, then 5.
  - Expect 2, 3, 4 on the retry path with `retry_lock_o` = 1.
  - Expect 5 forwarded downstream, `retry_count_o` = 1.
- Give-up, `MaxRetries` = 3: the same element fails at each of 4 consecutive resume points.
  - Expect 3 replay windows, then a forward with `error_o` = 1.
  - Expect `giveup_count_o` = 1, `attempts` back to 0.
- Stall: `valid_i` held on a failing element with `retry_ready_i` = 0 for 5 cycles.
  - Expect `ready_o` = 0 and no state or counter change until `retry_ready_i` rises.
  - Expect exactly one window opened.
- Saturation, `CntWidth` = 2: open 6 windows.
  - Expect `retry_count_o` to stick at 3.
- Reset during `REPLAY`: assert `rst_ni` = 0 mid-window.
  - Expect `PASS` and zero counters immediately.
  - Expect the next clean element forwarded downstream.

Source files
------------

// File: rtl/retry_pkg.sv
// Shared definitions for the retry stage family.
package retry_pkg;

  typedef enum logic {
    PASS   = 1'b0,
    REPLAY = 1'b1
  } retry_state_e;

endpackage

// File: rtl/retry_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module retry_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/retry_inorder_limited_end.sv
// In-order retry end stage with a bounded number of consecutive replay windows;
// after give-up the failing element is forwarded downstream flagged as an error.
module retry_inorder_limited_end
  import retry_pkg::*;
#(
  parameter type         DataType   = logic,
  parameter int unsigned IDSize     = 1,
  parameter int unsigned MaxRetries = 3,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  DataType             data_i,
  input  logic [IDSize-1:0]   id_i,
  input  logic                needs_retry_i,
  input  logic                valid_i,
  output logic                ready_o,
  output DataType             data_o,
  output logic                error_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [IDSize-1:0]   retry_id_o,
  input  logic [IDSize-1:0]   retry_id_i,
  output logic                retry_valid_o,
  output logic                retry_lock_o,
  input  logic                retry_ready_i,
  output logic [CntWidth-1:0] retry_count_o,
  output logic [CntWidth-1:0] giveup_count_o
);

  localparam int unsigned AttW   = $clog2(MaxRetries + 1);
  localparam logic [AttW-1:0] AttMax = AttW'(MaxRetries);

  retry_state_e      state_q, state_d;
  logic [IDSize-1:0] resume_id_q, resume_id_d;
  logic [AttW-1:0]   attempts_q, attempts_d;

  logic in_window;
  logic route_retry;
  logic fire;
  logic open_window;
  logic giveup;

  assign data_o     = data_i;
  assign retry_id_o = id_i;

  always_comb begin
    // Elements between the failure and the resume point are replayed unconditionally;
    // the resume element itself is judged like a fresh element in PASS.
    in_window   = (state_q == REPLAY) && (id_i != resume_id_q);
    route_retry = in_window ? valid_i
                            : (valid_i & needs_retry_i & (attempts_q < AttMax));

    if (route_retry) begin
      retry_valid_o = valid_i;
      ready_o       = retry_ready_i;
      valid_o       = 1'b0;
    end else begin
      retry_valid_o = 1'b0;
      ready_o       = ready_i;
      valid_o       = valid_i;
    end
    error_o = valid_o & needs_retry_i;

    fire        = valid_i & ready_o;
    open_window = fire & route_retry & ~in_window;
    giveup      = fire & ~route_retry & needs_retry_i;

    state_d     = state_q;
    resume_id_d = resume_id_q;
    attempts_d  = attempts_q;
    if (open_window) begin
      state_d     = REPLAY;
      resume_id_d = retry_id_i;
      attempts_d  = attempts_q + AttW'(1);
    end else if (fire && !route_retry) begin
      state_d    = PASS;
      attempts_d = '0;
    end

    retry_lock_o = route_retry | (state_d == REPLAY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PASS;
      resume_id_q <= '0;
      attempts_q  <= '0;
    end else begin
      state_q     <= state_d;
      resume_id_q <= resume_id_d;
      attempts_q  <= attempts_d;
    end
  end

  retry_sat_counter #(
    .Width (CntWidth)
  ) u_retry_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (open_window),
    .count_o (retry_count_o)
  );

  retry_sat_counter #(
    .Width (CntWidth)
  ) u_giveup_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (giveup),
    .count_o (giveup_count_o)
  );

endmodule

// File: tb/tb_retry_inorder_limited_end.sv
// Scoreboard bench for retry_inorder_limited_end (IDSize=3, MaxRetries=3, CntWidth=2).
module tb_retry_inorder_limited_end;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic [2:0] id_i;
  logic       needs_retry_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       error_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] retry_id_o;
  logic [2:0] retry_id_i;
  logic       retry_valid_o;
  logic       retry_lock_o;
  logic       retry_ready_i;
  logic [1:0] retry_count_o;
  logic [1:0] giveup_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       dn;
    logic       rt;
    logic [2:0] id;
    logic [7:0] data;
    logic       err;
    logic       lock;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_exp;
  xfer_t mon_act;

  retry_inorder_limited_end #(
    .DataType   (logic [7:0]),
    .IDSize     (3),
    .MaxRetries (3),
    .CntWidth   (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .data_i         (data_i),
    .id_i           (id_i),
    .needs_retry_i  (needs_retry_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .error_o        (error_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .retry_id_o     (retry_id_o),
    .retry_id_i     (retry_id_i),
    .retry_valid_o  (retry_valid_o),
    .retry_lock_o   (retry_lock_o),
    .retry_ready_i  (retry_ready_i),
    .retry_count_o  (retry_count_o),
    .giveup_count_o (giveup_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted transfer pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && valid_i && ready_o) begin
      checks++;
      mon_act = '{dn: valid_o, rt: retry_valid_o, id: retry_id_o, data: data_o,
                  err: error_o, lock: retry_lock_o};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected got %h with empty queue", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL xfer id=%0d got dn=%b rt=%b id=%0d data=%h err=%b lock=%b want dn=%b rt=%b id=%0d data=%h err=%b lock=%b",
                   mon_exp.id, mon_act.dn, mon_act.rt, mon_act.id, mon_act.data, mon_act.err, mon_act.lock,
                   mon_exp.dn, mon_exp.rt, mon_exp.id, mon_exp.data, mon_exp.err, mon_exp.lock);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  function automatic logic [7:0] pay(input logic [2:0] id);
    return 8'(int'(id) * 37 + 11);
  endfunction

  // Drive one element for one cycle; both readies are expected high.
  task automatic send(input logic [2:0] id, input logic nr, input logic [2:0] rid,
                      input logic exp_rt, input logic exp_err, input logic exp_lock);
    exp_q.push_back('{dn: ~exp_rt, rt: exp_rt, id: id, data: pay(id), err: exp_err, lock: exp_lock});
    id_i          = id;
    data_i        = pay(id);
    needs_retry_i = nr;
    retry_id_i    = rid;
    valid_i       = 1'b1;
    @(posedge clk);
    #1;
    valid_i       = 1'b0;
    needs_retry_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    valid_i       = 1'b0;
    data_i        = '0;
    id_i          = '0;
    needs_retry_i = 1'b0;
    retry_id_i    = '0;
    ready_i       = 1'b1;
    retry_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_retry_valid_o", int'(retry_valid_o), 0);
    chk("rst_error_o", int'(error_o), 0);
    chk("rst_lock_o", int'(retry_lock_o), 0);
    chk("rst_retry_count", int'(retry_count_o), 0);
    chk("rst_giveup_count", int'(giveup_count_o), 0);

    // Clean stream
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("clean_retry_count", int'(retry_count_o), 0);
    chk("clean_giveup_count", int'(giveup_count_o), 0);

    // Single failure: ID 2 fails, resume point 5
    do_reset();
    send(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    send(3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    send(3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
    send(3'd3, 1'b0, 3'd6, 1'b1, 1'b0, 1'b1);
    send(3'd4, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1);
    send(3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("single_retry_count", int'(retry_count_o), 1);
    chk("single_giveup_count", int'(giveup_count_o), 0);

    // Give-up: the element fails at every resume point
    do_reset();
    send(3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    send(3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    send(3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    send(3'd3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    chk("giveup_retry_count", int'(retry_count_o), 3);
    chk("giveup_giveup_count", int'(giveup_count_o), 1);
    // attempts cleared: a fresh failure opens a window again
    send(3'd4, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
    chk("giveup_sat_retry_count", int'(retry_count_o), 3);

    // Stall on the retry path
    do_reset();
    retry_ready_i = 1'b0;
    id_i          = 3'd0;
    data_i        = pay(3'd0);
    needs_retry_i = 1'b1;
    retry_id_i    = 3'd1;
    valid_i       = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready_o", int'(ready_o), 0);
      chk("stall_route", int'({retry_valid_o, valid_o, retry_lock_o}), 3'b101);
      chk("stall_retry_count", int'(retry_count_o), 0);
      @(posedge clk);
      #1;
    end
    exp_q.push_back('{dn: 1'b0, rt: 1'b1, id: 3'd0, data: pay(3'd0), err: 1'b0, lock: 1'b1});
    retry_ready_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i       = 1'b0;
    needs_retry_i = 1'b0;
    chk("stall_one_window", int'(retry_count_o), 1);
    send(3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("stall_after_resume", int'(retry_count_o), 1);

    // Saturation: six windows with CntWidth=2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send(3'(2 * k), 1'b1, 3'(2 * k + 1), 1'b1, 1'b0, 1'b1);
      send(3'(2 * k + 1), 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("sat_retry_count", int'(retry_count_o), 3);
    chk("sat_giveup_count", int'(giveup_count_o), 0);

    // Reset in the middle of a replay window
    do_reset();
    send(3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    chk("mid_pre_retry_count", int'(retry_count_o), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_retry_count", int'(retry_count_o), 0);
    chk("mid_rst_lock", int'(retry_lock_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
